halt_controller: RTL and testbench

- Producer side of the CPU end-of-run interface: generates the halt level and the 16-bit return value that the simulation cycle monitor consumes.
- Sits after the writeback stage of the pipelined CPU. Detects a retiring halt instruction, freezes fetch, and drains in-flight work (fixed drain window plus outstanding memory traffic) before asserting halt.
- Also owns a synthesizable cycle counter and watchdog, so hardware runs report runaway programs.

---
 rtl/halt_controller_if.sv | 25 ++
 rtl/halt_controller.sv | 85 ++++++++
 tb/tb_halt_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_controller_if.sv
// End-of-run bus between the CPU writeback/memory stages and the halt controller.
// master = pipeline side, slave = halt controller.
interface halt_controller_if #(
    parameter int DATA_W = 16
);
    logic              wb_valid;
    logic              wb_is_halt;
    logic [DATA_W-1:0] wb_ret_val;
    logic              mem_busy;
    logic              stop_fetch;
    logic              is_halt;
    logic [DATA_W-1:0] ret_val;
    logic              timeout;
    logic [31:0]       cycle_count;

    modport master (
        output wb_valid, wb_is_halt, wb_ret_val, mem_busy,
        input  stop_fetch, is_halt, ret_val, timeout, cycle_count
    );

    modport slave (
        input  wb_valid, wb_is_halt, wb_ret_val, mem_busy,
        output stop_fetch, is_halt, ret_val, timeout, cycle_count
    );
endinterface

// File: rtl/halt_controller.sv
// Catches a retiring halt, freezes fetch, drains the pipeline and memory, then raises is_halt.
// Also runs a free cycle counter with a watchdog that ends runaway programs in TIMED_OUT.
module halt_controller #(
    parameter int DATA_W         = 16,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    halt_controller_if.slave    bus
);
    localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_DRAIN     = 2'd1;
    localparam logic [1:0] ST_HALTED    = 2'd2;
    localparam logic [1:0] ST_TIMED_OUT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic [DATA_W-1:0] ret_val_q, ret_val_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              stop_fetch_q, is_halt_q, timeout_q;
    logic              wd_hit;

    assign wd_hit = (cycle_q == 32'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        ret_val_d = ret_val_q;
        cycle_d   = cycle_q;
        case (state_q)
            ST_RUN: begin
                cycle_d = cycle_q + 32'd1;
                // A retiring halt takes priority over a watchdog hit on the same edge.
                if (bus.wb_valid && bus.wb_is_halt) begin
                    ret_val_d = bus.wb_ret_val;
                    drain_d   = DCW'(DRAIN_CYCLES);
                    state_d   = ST_DRAIN;
                end else if (wd_hit) begin
                    state_d = ST_TIMED_OUT;
                end
            end
            ST_DRAIN: begin
                cycle_d = cycle_q + 32'd1;
                if (drain_q == '0 && !bus.mem_busy) begin
                    state_d = ST_HALTED;
                end else if (wd_hit) begin
                    state_d = ST_TIMED_OUT;
                end else if (drain_q != '0) begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            drain_q      <= '0;
            ret_val_q    <= '0;
            cycle_q      <= '0;
            stop_fetch_q <= 1'b0;
            is_halt_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            ret_val_q    <= ret_val_d;
            cycle_q      <= cycle_d;
            // Outputs decoded from next state so they track state_q without a lag.
            stop_fetch_q <= (state_d != ST_RUN);
            is_halt_q    <= (state_d == ST_HALTED);
            timeout_q    <= (state_d == ST_TIMED_OUT);
        end
    end

    assign bus.stop_fetch  = stop_fetch_q;
    assign bus.is_halt     = is_halt_q;
    assign bus.timeout     = timeout_q;
    assign bus.ret_val     = ret_val_q;
    assign bus.cycle_count = cycle_q;
endmodule

// File: tb/tb_halt_controller.sv
// Scoreboarded bench for halt_controller: three parameterisations, one selected per test.
module tb_halt_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    halt_controller_if #(.DATA_W(16)) ifa ();
    halt_controller_if #(.DATA_W(16)) ifb ();
    halt_controller_if #(.DATA_W(16)) ifc ();

    halt_controller #(.DATA_W(16), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    halt_controller #(.DATA_W(16), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));
    halt_controller #(.DATA_W(16), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(1000)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave));

    int          sel = 0;
    logic        t_valid = 1'b0, t_halt = 1'b0, t_busy = 1'b0;
    logic [15:0] t_ret = '0;

    assign ifa.wb_valid   = (sel == 0) && t_valid;
    assign ifa.wb_is_halt = (sel == 0) && t_halt;
    assign ifa.wb_ret_val = (sel == 0) ? t_ret : 16'h0;
    assign ifa.mem_busy   = (sel == 0) && t_busy;
    assign ifb.wb_valid   = (sel == 1) && t_valid;
    assign ifb.wb_is_halt = (sel == 1) && t_halt;
    assign ifb.wb_ret_val = (sel == 1) ? t_ret : 16'h0;
    assign ifb.mem_busy   = (sel == 1) && t_busy;
    assign ifc.wb_valid   = (sel == 2) && t_valid;
    assign ifc.wb_is_halt = (sel == 2) && t_halt;
    assign ifc.wb_ret_val = (sel == 2) ? t_ret : 16'h0;
    assign ifc.mem_busy   = (sel == 2) && t_busy;

    logic        o_sf, o_halt, o_to;
    logic [15:0] o_ret;
    logic [31:0] o_cc;
    always_comb begin
        o_sf = ifa.stop_fetch; o_halt = ifa.is_halt; o_to = ifa.timeout;
        o_ret = ifa.ret_val; o_cc = ifa.cycle_count;
        if (sel == 1) begin
            o_sf = ifb.stop_fetch; o_halt = ifb.is_halt; o_to = ifb.timeout;
            o_ret = ifb.ret_val; o_cc = ifb.cycle_count;
        end else if (sel == 2) begin
            o_sf = ifc.stop_fetch; o_halt = ifc.is_halt; o_to = ifc.timeout;
            o_ret = ifc.ret_val; o_cc = ifc.cycle_count;
        end
    end

    // Edges counted from reset release; edge 1 is the first edge with rst low.
    int edge_n = 0;
    always @(posedge clk) begin
        if (rst) edge_n = 0;
        else     edge_n++;
    end

    typedef struct {
        int          edge_no;
        logic [15:0] ret;
        logic [31:0] cc;
        logic        halt;
        logic        to;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: a terminal output (is_halt or timeout) rising is the DUT's response.
    logic prev_term = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_term = 1'b0;
        end else begin
            if ((o_halt || o_to) && !prev_term) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_terminal: halt=%0b timeout=%0b at edge %0d, none expected",
                             o_halt, o_to, edge_n);
                end else begin
                    m_e = sb.pop_front();
                    chk("term_edge", 32'(edge_n), 32'(m_e.edge_no));
                    chk("ret_val", {16'h0, o_ret}, {16'h0, m_e.ret});
                    chk("cycle_count", o_cc, m_e.cc);
                    chk("is_halt", {31'h0, o_halt}, {31'h0, m_e.halt});
                    chk("timeout", {31'h0, o_to}, {31'h0, m_e.to});
                    chk("stop_fetch_term", {31'h0, o_sf}, 32'h1);
                end
            end
            prev_term = o_halt || o_to;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int s);
        rst = 1'b1;
        t_valid = 1'b0; t_halt = 1'b0; t_busy = 1'b0; t_ret = '0;
        sel = s;
        step(2);
        chk("reset_flags", {29'h0, o_sf, o_halt, o_to}, 32'h0);
        chk("reset_ret", {16'h0, o_ret}, 32'h0);
        chk("reset_cc", o_cc, 32'h0);
        rst = 1'b0;
    endtask

    task automatic push(input int e, input logic [15:0] r, input logic [31:0] c,
                        input logic h, input logic t);
        exp_t x;
        x.edge_no = e; x.ret = r; x.cc = c; x.halt = h; x.to = t;
        sb.push_back(x);
    endtask

    task automatic wait_sb(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        step(1);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        // Basic halt, DRAIN_CYCLES=4: halt sampled at edge 10, HALTED at edge 15.
        do_reset(0);
        step(9);
        chk("basic_sf_before", {31'h0, o_sf}, 32'h0);
        push(15, 16'h002A, 32'd15, 1'b1, 1'b0);
        t_valid = 1'b1; t_halt = 1'b1; t_ret = 16'h002A;
        step(1);
        t_valid = 1'b0; t_halt = 1'b0; t_ret = 16'h1111;
        chk("basic_sf_next", {31'h0, o_sf}, 32'h1);
        chk("basic_halt_early", {31'h0, o_halt}, 32'h0);
        wait_sb(20);
        step(3);
        chk("basic_cc_frozen", o_cc, 32'd15);

        // Memory drain: mem_busy high for edges 11..20, HALTED at edge 21.
        do_reset(0);
        step(9);
        push(21, 16'h0055, 32'd21, 1'b1, 1'b0);
        t_valid = 1'b1; t_halt = 1'b1; t_ret = 16'h0055;
        step(1);
        t_valid = 1'b0; t_halt = 1'b0; t_busy = 1'b1;
        step(10);
        chk("mem_halt_early", {31'h0, o_halt}, 32'h0);
        t_busy = 1'b0;
        wait_sb(10);

        // Watchdog, TIMEOUT_CYCLES=20: TIMED_OUT at edge 21, count frozen at 21.
        do_reset(1);
        push(21, 16'h0000, 32'd21, 1'b0, 1'b1);
        step(20);
        chk("wd_not_yet", {30'h0, o_to, o_sf}, 32'h0);
        wait_sb(10);
        step(5);
        chk("wd_cc_hold", o_cc, 32'd21);
        chk("wd_flags", {29'h0, o_sf, o_halt, o_to}, 32'b101);
        chk("wd_ret", {16'h0, o_ret}, 32'h0);

        // Halt on the watchdog edge wins; a second halt in DRAIN is ignored.
        do_reset(1);
        push(26, 16'h0007, 32'd26, 1'b1, 1'b0);
        step(20);
        chk("coll_cc20", o_cc, 32'd20);
        t_valid = 1'b1; t_halt = 1'b1; t_ret = 16'h0007;
        step(1);
        t_valid = 1'b0; t_halt = 1'b0;
        chk("coll_drain", {30'h0, o_to, o_sf}, 32'b01);
        step(1);
        t_valid = 1'b1; t_halt = 1'b1; t_ret = 16'h0009;
        step(1);
        t_valid = 1'b0; t_halt = 1'b0;
        chk("dup_ret_kept", {16'h0, o_ret}, 32'h7);
        wait_sb(10);

        // Async reset two cycles into DRAIN.
        do_reset(0);
        step(9);
        t_valid = 1'b1; t_halt = 1'b1; t_ret = 16'hBEEF;
        step(1);
        t_valid = 1'b0; t_halt = 1'b0;
        step(2);
        chk("rstmid_in_drain", {31'h0, o_sf}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_flags", {29'h0, o_sf, o_halt, o_to}, 32'h0);
        chk("rstmid_ret", {16'h0, o_ret}, 32'h0);
        chk("rstmid_cc", o_cc, 32'h0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("rstmid_cc_restart", o_cc, 32'd3);
        chk("rstmid_run", {31'h0, o_sf}, 32'h0);

        // DRAIN_CYCLES=0: HALTED on the edge right after the halt edge.
        do_reset(2);
        step(9);
        push(11, 16'hFFFF, 32'd11, 1'b1, 1'b0);
        t_valid = 1'b1; t_halt = 1'b1; t_ret = 16'hFFFF;
        step(1);
        t_valid = 1'b0; t_halt = 1'b0;
        chk("d0_halt_early", {31'h0, o_halt}, 32'h0);
        wait_sb(5);

        // wb_is_halt without wb_valid does nothing.
        do_reset(2);
        step(3);
        t_halt = 1'b1; t_ret = 16'h00AA;
        step(2);
        t_halt = 1'b0;
        chk("novalid_ignored", {15'h0, o_sf, o_ret}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
